// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle SLL/SRL/SRA/ROL unit shifting up to STEP bits per cycle,
// with a valid/ready handshake on both the operand and the held result.
module iterative_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy
);
    localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
    localparam logic [1:0] M_SLL = 2'd0, M_SRL = 2'd1, M_SRA = 2'd2;
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_rem;
    logic [1:0]         r_mode;
    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W:0]   w_ror;
    logic               w_last;
    logic [WIDTH-1:0]   w_step;
    // Compare one bit wider so STEP == WIDTH never wraps.
    always_comb begin
        w_last = {1'b0, r_rem} <= (SHAMT_W+1)'(STEP);
        w_k    = w_last ? r_rem : SHAMT_W'(STEP);
        w_ror  = (SHAMT_W+1)'(WIDTH) - {1'b0, w_k};
        w_step = r_mode == M_SLL ? r_data << w_k :
                 r_mode == M_SRL ? r_data >> w_k :
                 r_mode == M_SRA ? WIDTH'($signed(r_data) >>> w_k) :
                 (r_data << w_k) | (r_data >> w_ror);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_mode  <= M_SLL;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_data  <= operand;
            r_rem   <= shamt;
            r_mode  <= mode;
            r_state <= shamt == '0 ? S_DONE : S_SHIFT;
        end else if (r_state == S_SHIFT) begin
            r_data  <= w_step;
            r_rem   <= r_rem - w_k;
            if (w_last) r_state <= S_DONE;
        end else if (r_state == S_DONE && out_ready) begin
            r_state <= S_IDLE;
        end
    end
    assign in_ready  = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign busy      = r_state != S_IDLE;
    assign result    = r_data;
endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter: directed and random operations on a WIDTH=32, STEP=4 shifter,
// checked against an arithmetic reference model and a shift-cycle count model.
module tb_iterative_shifter;
    localparam int W = 32;
    localparam int STEP = 4;
    localparam int LIM = 100;
    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] operand = '0;
    logic [4:0]   shamt = '0;
    logic [1:0]   mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         busy;
    int n_cmp = 0;
    int n_bad = 0;

    iterative_shifter #(.WIDTH(W), .STEP(STEP)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand(operand), .shamt(shamt), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the whole shift amount at once.
    function automatic logic [W-1:0] model(input logic [W-1:0] v, input int sh, input logic [1:0] m);
        logic [2*W-1:0] d;
        d = {v, v} << sh;
        case (m)
            2'd0: return v << sh;
            2'd1: return v >> sh;
            2'd2: return v[W-1] ? ~((~v) >> sh) : v >> sh;
            default: return d[2*W-1:W];
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] op, input int sh, input logic [1:0] md);
        int n = 0;
        while (!in_ready && n < LIM) begin tick(); n++; end
        chk("in_ready_before_accept", W'(in_ready), W'(1));
        operand = op; shamt = 5'(sh); mode = md; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] op, input int sh, input logic [1:0] md, input int hold);
        int n = 0;
        logic [W-1:0] exp;
        exp = model(op, sh, md);
        accept(op, sh, md);
        chk("busy_after_accept", W'(busy), W'(1));
        chk("in_ready_after_accept", W'(in_ready), W'(0));
        while (!out_valid && n < LIM) begin tick(); n++; end
        chk("shift_cycles", W'(n), W'((sh + STEP - 1) / STEP));
        chk("out_valid", W'(out_valid), W'(1));
        chk($sformatf("result_m%0d_s%0d", md, sh), result, exp);
        for (int i = 0; i < hold; i++) begin
            operand = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
            tick();
            chk("hold_result", result, exp);
            chk("hold_in_ready", W'(in_ready), W'(0));
            chk("hold_out_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_handshake", W'(out_valid), W'(0));
        chk("in_ready_after_handshake", W'(in_ready), W'(1));
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_result", result, '0);
        reset_n = 1'b1;
        tick();
        run_op(32'h0000_0123, 2, 2'd0, 0);
        run_op(32'h8000_00F0, 7, 2'd2, 0);
        run_op(32'h8000_00F0, 7, 2'd1, 0);
        run_op(32'h8000_0001, 31, 2'd3, 0);
        for (int m = 0; m < 4; m++) run_op(32'hA5C3_1E77, 0, 2'(m), 0);
        run_op(32'h1234_5678, 13, 2'd2, 10);
        // Asynchronous reset in the middle of a shift.
        accept(32'hFFFF_FFFF, 20, 2'd0);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_in_ready", W'(in_ready), W'(1));
        chk("midrst_result", result, '0);
        chk("midrst_busy", W'(busy), W'(0));
        tick();
        reset_n = 1'b1;
        tick();
        run_op(32'hFFFF_FFFF, 20, 2'd0, 0);
        // Flush during the second shift cycle.
        accept(32'hDEAD_BEEF, 20, 2'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready", W'(in_ready), W'(1));
        chk("flush_busy", W'(busy), W'(0));
        for (int i = 0; i < 8; i++) begin
            chk("flush_no_out_valid", W'(out_valid), W'(0));
            tick();
        end
        // Flush together with in_valid in IDLE must not accept.
        operand = 32'h0F0F_0F0F; shamt = 5'd3; mode = 2'd0;
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_accept_busy", W'(busy), W'(0));
        chk("flush_accept_in_ready", W'(in_ready), W'(1));
        run_op(32'h0F0F_0F0F, 3, 2'd0, 0);
        for (int i = 0; i < 40; i++)
            run_op($urandom, int'($urandom_range(0, W - 1)), 2'($urandom), int'($urandom_range(0, 2)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
